inst_fetch: RTL and testbench

- Upstream fetch stage for the 8-bit processor. Holds an 8-entry x 8-bit instruction store and owns the program counter.
- Presents one instruction per advance on a registered `instruction`/`address` pair that the execute stage consumes.
- Replaces the execute stage's free-running divider with a controlled advance: timed run, single-step from a button, or halt with a write port for loading programs from board switches.

---
 rtl/inst_fetch_pkg.sv | 41 ++++
 rtl/inst_fetch_tick_gen.sv | 47 ++++
 rtl/inst_fetch.sv | 130 +++++++++++++
 tb/tb_inst_fetch.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_pkg
// Purpose  : Shared definitions for the fetch stage and its execute-stage
//            consumer: mode encodings, default widths, opcode field values
//            and the fetch state type.
// Revision : 1.0  initial release
// ============================================================================
package inst_fetch_pkg;

    localparam int DEF_ADDR_W = 3;
    localparam int DEF_INST_W = 8;

    // Encodings of the external mode selector.
    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    // Opcode field values decoded by the execute stage.
    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } fetch_state_e;

    // The unused encoding 2'b11 falls back to HALT.
    function automatic fetch_state_e mode_to_state(input logic [1:0] mode);
        fetch_state_e st;
        case (mode)
            MODE_RUN:  st = ST_RUN;
            MODE_STEP: st = ST_STEP;
            default:   st = ST_HALT;
        endcase
        return st;
    endfunction

endpackage
`default_nettype wire

// File: rtl/inst_fetch_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tick_gen
// Purpose  : Free-running 0..TICK_DIV-1 counter with synchronous clear and a
//            one-cycle terminal-count pulse.
// Ports    : clk  - system clock
//            rst  - asynchronous active-low reset
//            clr  - hold counter at zero (no pulse while asserted)
//            tick - high during the cycle the counter holds TICK_DIV-1
// Revision : 1.0  initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 10000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int               CNT_W    = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_w;

    always_comb begin
        tick_w = !clr && (cnt_q == CNT_LAST);
        cnt_d  = cnt_q + CNT_W'(1);
        if (clr || tick_w) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = tick_w;

endmodule
`default_nettype wire

// File: rtl/inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch
// Purpose  : Fetch stage: instruction store, program counter and controlled
//            advance (timed RUN, button STEP, HALT with program load port).
// Ports    : clk, rst (async active-low)
//            mode[1:0]     00 HALT, 01 RUN, 10 STEP, 11 HALT
//            step_btn      asynchronous step button, active-high
//            prog_we/prog_addr/prog_data  store write port (HALT only)
//            address       registered program counter
//            instruction   registered store[address]
//            inst_valid    one-cycle pulse with each new address/instruction
//            pc_wrap       one-cycle pulse when the PC wraps to zero
// Revision : 1.0  initial release
// ============================================================================
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INST_W   = DEF_INST_W,
    parameter int TICK_DIV = 10000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        mode,
    input  logic              step_btn,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [INST_W-1:0] prog_data,
    output logic [ADDR_W-1:0] address,
    output logic [INST_W-1:0] instruction,
    output logic              inst_valid,
    output logic              pc_wrap
);

    localparam int DEPTH = 2 ** ADDR_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;
    logic              wrap_q, wrap_d;
    logic              sync1_q, sync2_q, sync3_q;
    logic [INST_W-1:0] mem_q [DEPTH];
    logic [INST_W-1:0] mem_d [DEPTH];

    logic              run_tick;
    logic              step_rise;
    logic              advance;
    logic              do_write;
    logic [ADDR_W-1:0] addr_inc;

    // Counter only runs while the registered state is RUN, so leaving and
    // re-entering RUN always restarts a full interval.
    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (state_q != ST_RUN),
        .tick (run_tick)
    );

    always_comb begin
        state_d   = mode_to_state(mode);
        addr_inc  = addr_q + ADDR_W'(1);
        // sync1/sync2 form the synchronizer; sync3 is the edge-detect history.
        // They run in every state so an edge seen outside STEP is consumed
        // and never replayed later.
        step_rise = sync2_q && !sync3_q;
        advance   = ((state_q == ST_RUN)  && run_tick) ||
                    ((state_q == ST_STEP) && step_rise);
        do_write  = (state_q == ST_HALT) && prog_we;

        mem_d = mem_q;
        if (do_write) begin
            mem_d[prog_addr] = prog_data;
        end

        addr_d  = addr_q;
        inst_d  = inst_q;
        valid_d = 1'b0;
        wrap_d  = 1'b0;
        if (advance) begin
            // Read the entry for the new address so address and instruction
            // update together on the same edge.
            addr_d  = addr_inc;
            inst_d  = mem_q[addr_inc];
            valid_d = 1'b1;
            wrap_d  = (addr_q == {ADDR_W{1'b1}});
        end else if (do_write && (prog_addr == addr_q)) begin
            // Write-through keeps the presented instruction coherent with
            // the store while a program is being loaded.
            inst_d = prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HALT;
            addr_q  <= '0;
            inst_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            sync1_q <= step_btn;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            mem_q   <= mem_d;
        end
    end

    assign address     = addr_q;
    assign instruction = inst_q;
    assign inst_valid  = valid_q;
    assign pc_wrap     = wrap_q;

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch
// Purpose  : Self-checking bench for inst_fetch (TICK_DIV = 4). Expected
//            advances are queued as stimulus is applied and compared when
//            the DUT pulses inst_valid.
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_fetch;
    import inst_fetch_pkg::*;

    localparam int ADDR_W   = 3;
    localparam int INST_W   = 8;
    localparam int TICK_DIV = 4;
    localparam int DEPTH    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        mode = MODE_RUN;
    logic              step_btn = 1'b0;
    logic              prog_we = 1'b0;
    logic [ADDR_W-1:0] prog_addr = '0;
    logic [INST_W-1:0] prog_data = '0;
    logic [ADDR_W-1:0] address;
    logic [INST_W-1:0] instruction;
    logic              inst_valid;
    logic              pc_wrap;

    inst_fetch #(
        .ADDR_W   (ADDR_W),
        .INST_W   (INST_W),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .step_btn    (step_btn),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .address     (address),
        .instruction (instruction),
        .inst_valid  (inst_valid),
        .pc_wrap     (pc_wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [INST_W-1:0] i;
        logic              w;
    } exp_t;

    exp_t              exp_q[$];
    int                n_pass = 0;
    int                n_total = 0;
    int                seen_cnt = 0;
    int                last_valid_cyc = 0;
    int                prev_valid_cyc = 0;
    logic [INST_W-1:0] model_mem [DEPTH];
    logic [ADDR_W-1:0] model_addr;

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
        model_addr = '0;
        exp_q.delete();
    endtask

    // Queue the outcome of one advance from the model's current address.
    task automatic push_adv();
        exp_t e;
        e.w        = (model_addr == {ADDR_W{1'b1}});
        model_addr = model_addr + 3'd1;
        e.a        = model_addr;
        e.i        = model_mem[model_addr];
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_seen(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (seen_cnt >= target) break;
            tick(1);
        end
        if (seen_cnt >= target) ok = 1'b1;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst === 1'b1 && inst_valid === 1'b1) begin
                seen_cnt++;
                prev_valid_cyc = last_valid_cyc;
                last_valid_cyc = cyc;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL adv_unexpected: addr=%0d inst=%02h, expected no advance",
                             address, instruction);
                end else begin
                    e = exp_q.pop_front();
                    if ({address, instruction, pc_wrap} !== e) begin
                        $display("FAIL adv: addr=%0d inst=%02h wrap=%0b, expected addr=%0d inst=%02h wrap=%0b",
                                 address, instruction, pc_wrap, e.a, e.i, e.w);
                    end else begin
                        n_pass++;
                    end
                end
            end
            if (pc_wrap === 1'b1 && inst_valid !== 1'b1) begin
                n_total++;
                $display("FAIL pc_wrap_lone: pc_wrap=1 inst_valid=%0b, expected inst_valid=1",
                         inst_valid);
            end
        end
    endtask

    task automatic pulse_reset();
        #1 rst = 1'b0;
        #1 rst = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        bit ok;
        int rel_cyc;
        mode = MODE_RUN;
        rst  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            n_total++;
            if ({address, instruction, inst_valid, pc_wrap} !== 13'd0) begin
                $display("FAIL reset_quiet: addr=%0d inst=%02h valid=%0b wrap=%0b, expected all 0",
                         address, instruction, inst_valid, pc_wrap);
            end else n_pass++;
        end
        model_clear();
        rst     = 1'b1;
        rel_cyc = cyc;
        push_adv();
        wait_seen(1, 12, ok);
        mode = MODE_HALT;
        n_total++;
        if (!ok) $display("FAIL reset_first_adv: seen=%0d, expected 1", seen_cnt);
        else n_pass++;
        // State loads RUN one edge after release, then TICK_DIV edges elapse.
        n_total++;
        if ((last_valid_cyc - rel_cyc) < TICK_DIV || (last_valid_cyc - rel_cyc) > TICK_DIV + 1)
            $display("FAIL reset_latency: %0d cycles, expected %0d..%0d",
                     last_valid_cyc - rel_cyc, TICK_DIV, TICK_DIV + 1);
        else n_pass++;
        tick(2);
        pulse_reset();
        tick(1);
    endtask

    task automatic test_program_run();
        bit ok;
        int base;
        logic [INST_W-1:0] prog [3];
        prog[0] = 8'hC1; prog[1] = 8'h02; prog[2] = 8'h33;
        mode = MODE_HALT;
        tick(1);
        for (int k = 0; k < 3; k++) begin
            prog_we   = 1'b1;
            prog_addr = 3'(k);
            prog_data = prog[k];
            model_mem[k] = prog[k];
            tick(1);
            if (k == 0) begin
                n_total++;
                if (instruction !== 8'hC1 || inst_valid !== 1'b0)
                    $display("FAIL load_write_through: inst=%02h valid=%0b, expected C1 valid=0",
                             instruction, inst_valid);
                else n_pass++;
            end
        end
        prog_we = 1'b0;
        base = seen_cnt;
        mode = MODE_RUN;
        push_adv();
        push_adv();
        wait_seen(base + 2, 20, ok);
        n_total++;
        if (!ok) $display("FAIL run_two_adv: seen=%0d, expected %0d", seen_cnt - base, 2);
        else n_pass++;
        n_total++;
        if (last_valid_cyc - prev_valid_cyc != TICK_DIV)
            $display("FAIL run_interval: %0d cycles, expected %0d",
                     last_valid_cyc - prev_valid_cyc, TICK_DIV);
        else n_pass++;
    endtask

    task automatic test_wrap();
        bit ok;
        int base;
        base = seen_cnt;
        for (int k = 0; k < 6; k++) push_adv();
        wait_seen(base + 6, 40, ok);
        mode = MODE_HALT;
        n_total++;
        if (!ok) $display("FAIL wrap_adv: seen=%0d, expected %0d", seen_cnt - base, 6);
        else n_pass++;
        tick(1);
        n_total++;
        if (pc_wrap !== 1'b0 || address !== 3'd0 || instruction !== 8'hC1)
            $display("FAIL wrap_after: wrap=%0b addr=%0d inst=%02h, expected 0/0/C1",
                     pc_wrap, address, instruction);
        else n_pass++;
    endtask

    task automatic test_step();
        bit ok;
        int base;
        int btn_cyc;
        mode = MODE_STEP;
        tick(2);
        base = seen_cnt;
        push_adv();
        step_btn = 1'b1;
        btn_cyc  = cyc;
        tick(20);
        step_btn = 1'b0;
        n_total++;
        if (seen_cnt - base != 1)
            $display("FAIL step_held: %0d advances, expected 1", seen_cnt - base);
        else n_pass++;
        n_total++;
        if (last_valid_cyc - btn_cyc != 3)
            $display("FAIL step_latency: %0d cycles, expected 3", last_valid_cyc - btn_cyc);
        else n_pass++;
        tick(3);
        // Edge detected while halted must be dropped, not deferred.
        mode = MODE_HALT;
        tick(1);
        base = seen_cnt;
        step_btn = 1'b1;
        tick(2);
        step_btn = 1'b0;
        tick(5);
        mode = MODE_STEP;
        tick(10);
        n_total++;
        if (seen_cnt != base)
            $display("FAIL step_discard: %0d advances, expected 0", seen_cnt - base);
        else n_pass++;
        push_adv();
        step_btn = 1'b1;
        tick(2);
        step_btn = 1'b0;
        wait_seen(base + 1, 8, ok);
        n_total++;
        if (!ok) $display("FAIL step_second: seen=%0d, expected 1", seen_cnt - base);
        else n_pass++;
        mode = MODE_HALT;
        tick(2);
    endtask

    task automatic test_write_through();
        bit ok;
        int base;
        prog_we = 1'b1; prog_addr = 3'd2; prog_data = 8'hAA;
        model_mem[2] = 8'hAA;
        tick(1);
        prog_we = 1'b0;
        n_total++;
        if (instruction !== 8'hAA || inst_valid !== 1'b0)
            $display("FAIL halt_write_through: inst=%02h valid=%0b, expected AA valid=0",
                     instruction, inst_valid);
        else n_pass++;
        prog_we = 1'b1; prog_addr = 3'd6; prog_data = 8'h66;
        model_mem[6] = 8'h66;
        tick(1);
        prog_we = 1'b0;
        n_total++;
        if (instruction !== 8'hAA || address !== 3'd2)
            $display("FAIL halt_write_other: inst=%02h addr=%0d, expected AA addr 2",
                     instruction, address);
        else n_pass++;
        base = seen_cnt;
        mode = MODE_RUN;
        tick(1);
        prog_we = 1'b1; prog_addr = 3'd2; prog_data = 8'h55;
        tick(1);
        prog_we = 1'b0;
        n_total++;
        if (instruction !== 8'hAA)
            $display("FAIL run_write_ignored: inst=%02h, expected AA", instruction);
        else n_pass++;
        // Full lap back to 2 proves the store kept AA; stop at address 5.
        for (int k = 0; k < 11; k++) push_adv();
        wait_seen(base + 11, 70, ok);
        n_total++;
        if (!ok) $display("FAIL run_lap: seen=%0d, expected %0d", seen_cnt - base, 11);
        else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int base;
        n_total++;
        if (address !== 3'd5 || exp_q.size() != 0)
            $display("FAIL pre_reset: addr=%0d pending=%0d, expected addr 5 pending 0",
                     address, exp_q.size());
        else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_total++;
        if (address !== 3'd0 || instruction !== 8'h00 || inst_valid !== 1'b0)
            $display("FAIL mid_reset: addr=%0d inst=%02h valid=%0b, expected 0/00/0",
                     address, instruction, inst_valid);
        else n_pass++;
        rst = 1'b1;
        model_clear();
        base = seen_cnt;
        for (int k = 0; k < 8; k++) push_adv();
        wait_seen(base + 8, 60, ok);
        mode = MODE_HALT;
        n_total++;
        if (!ok) $display("FAIL post_reset_lap: seen=%0d, expected %0d", seen_cnt - base, 8);
        else n_pass++;
        tick(2);
    endtask

    initial begin
        model_clear();
        fork
            monitor();
        join_none
        test_reset();
        test_program_run();
        test_wrap();
        test_step();
        test_write_through();
        test_reset_mid_run();
        n_total++;
        if (exp_q.size() != 0)
            $display("FAIL leftover: %0d expected advances never seen, expected 0", exp_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
